core_sequencer: RTL
===================

Name: core_sequencer

Overview:
Multi-cycle sequencer that drives the RV32 R-type core through FETCH, DECODE, EXECUTE and WRITEBACK.
- Owns the PC and the instruction register.
- Runs the request/acknowledge handshake to instruction memory.
- Gates the CONTROL regwrite so the register file is written only in the writeback cycle.
- Sits between instruction memory and the CONTROL/DATAPATH pair. It replaces free-running single-cycle fetch.

Parameters:
PC_WIDTH, 32, PC/address width
RESET_PC, 0, PC value after reset
PC_STEP, 4, PC increment per retired instruction
FETCH_TIMEOUT, 15, cycles in FETCH without ack before error; 0 disables the timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  level; allows execution to start or continue
halt_req  input  1  level; stop at the next instruction boundary
clear  input  1  pulse; leave HALTED/ERROR and return to IDLE
imem_req  output  1  fetch request
imem_addr  output  PC_WIDTH  fetch address (= PC)
imem_ack  input  1  fetch data valid
imem_rdata  input  32  fetched instruction
ir  output  32  instruction register, fed to CONTROL/DATAPATH fields
alu_en  output  1  execute strobe
ctrl_regwrite  input  1  regwrite decoded by CONTROL
regwrite  output  1  gated regwrite to DATAPATH
halted  output  1  state == HALTED
fetch_err  output  1  sticky: fetch timeout
illegal_instr  output  1  sticky: unsupported opcode

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, PC=RESET_PC, ir=0, timer=0.
  - All strobes and flags are 0.
  - Reset mid-instruction aborts it; no regwrite is issued.
- Each output is a registered state decode, except regwrite = (state==WRITEBACK) & ctrl_regwrite.
- IDLE: run=1 & halt_req=0 -> FETCH.
- FETCH:
  - imem_req=1 and imem_addr=PC, both held stable until ack.
  - imem_ack=1 -> ir<=imem_rdata, go to DECODE, timer cleared.
  - Otherwise timer increments. When timer reaches FETCH_TIMEOUT (nonzero) -> ERROR, fetch_err=1.
  - An ack in the same cycle as the timeout wins.
  - imem_ack outside FETCH is ignored.
- DECODE: check ir[6:0].
  - 0110011 (R-type) -> EXECUTE.
  - 1110011 (SYSTEM/ebreak) -> HALTED; PC is not advanced.
  - Any other opcode -> ERROR, illegal_instr=1.
- EXECUTE: alu_en=1 for exactly one cycle -> WRITEBACK.
- WRITEBACK:
  - regwrite issued for one cycle.
  - PC <= PC+PC_STEP, modulo 2^PC_WIDTH (wrap allowed, no flag).
  - Next state: halt_req=1 -> HALTED; run=0 -> IDLE; else FETCH.
- halt_req is honoured only in IDLE (-> HALTED) and at WRITEBACK. An instruction in flight always completes.
- HALTED / ERROR: hold state, PC and ir.
  - clear=1 -> IDLE; sticky flags and timer cleared; PC kept.
  - clear is ignored in other states.
- Throughput: 4 cycles per instruction when ack arrives in the first FETCH cycle. Each cycle of ack wait adds 1.

Optional Feature:
SEQ_RETIRE_CNT_EN:
- When defined: adds output retire_count (32 bits). It resets to 0 and increments by 1 in each WRITEBACK cycle, wrapping at 2^32.
- clear does not reset it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package core_seq_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, ERROR
  - opcode constants: OPC_RTYPE=7'b0110011, OPC_SYSTEM=7'b1110011
- One sub-module, seq_fetch_timer: parameterised timeout counter with inputs clear/enable and output expired. Its width is $clog2(FETCH_TIMEOUT+1); when FETCH_TIMEOUT=0, expired is tied to 0.

Test Plan:
- Reset release, run=1, memory acks immediately with 0x002081B3 (add x3,x1,x2):
  - imem_addr=0 in the first FETCH cycle.
  - alu_en 2 cycles after the ack.
  - regwrite one cycle later, then imem_addr=4.
  - 4-cycle cadence.
- Ack delayed 3 cycles: imem_req and imem_addr held stable throughout, ir loaded on the ack cycle, exactly one regwrite.
- No ack, FETCH_TIMEOUT=15: ERROR entered after 15 FETCH cycles with fetch_err=1; then clear -> IDLE, fetch_err=0, PC unchanged.
- Fetch returns 0x00000013 (I-type): illegal_instr=1, no alu_en, no regwrite. Fetch returns 0x00100073 (ebreak): halted=1, PC unchanged.
- halt_req raised mid-EXECUTE: the instruction retires (regwrite=1) and the next state is HALTED. reset driven low during DECODE: every output returns to its reset value immediately.
- RESET_PC=0xFFFFFFFC: after one retire imem_addr=0x00000000. With SEQ_RETIRE_CNT_EN, retire_count=1.

Source files
------------

// File: rtl/core_seq_pkg.sv
// core_seq_pkg: state encoding and opcode constants shared by core_sequencer and its testbench
package core_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, ERROR} seq_state_t;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

// File: rtl/core_sequencer_if.sv
// core_sequencer_if: instruction-memory bus; master drives req/addr, slave returns ack/rdata
interface core_sequencer_if #(parameter int PC_WIDTH = 32);
  logic req;
  logic [PC_WIDTH-1:0] addr;
  logic ack;
  logic [31:0] rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/seq_fetch_timer.sv
// seq_fetch_timer: counts enabled cycles; expired flags the cycle that would reach FETCH_TIMEOUT (0 = never)
// ports: clock, reset (async active-low), clear (zero the count), enable (count this cycle), expired
module seq_fetch_timer #(parameter int FETCH_TIMEOUT = 15) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  if (FETCH_TIMEOUT == 0) begin : g_off
    logic unused;
    assign unused = &{clock, reset, clear, enable};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int W = $clog2(FETCH_TIMEOUT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clock or negedge reset)
      if (!reset) count <= '0;
      else count <= clear ? '0 : enable ? count + W'(1) : count;
    assign expired = enable && count == W'(FETCH_TIMEOUT - 1);
  end
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer owning PC and IR
// ports: clock, reset (async active-low), run, halt_req, clear, imem (req/addr/ack/rdata),
//        ir, alu_en, ctrl_regwrite -> regwrite (writeback only), halted, fetch_err, illegal_instr
// SEQ_RETIRE_CNT_EN: adds retire_count, a free-running count of retired instructions
module core_sequencer import core_seq_pkg::*; #(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic halt_req,
  input  logic clear,
  core_sequencer_if.master imem,
  output logic [31:0] ir,
  output logic alu_en,
  input  logic ctrl_regwrite,
  output logic regwrite,
  output logic halted,
  output logic fetch_err,
  output logic illegal_instr
`ifdef SEQ_RETIRE_CNT_EN
  , output logic [31:0] retire_count
`endif
);
  seq_state_t state, state_n;
  logic [PC_WIDTH-1:0] pc;
  logic expired;
  seq_fetch_timer #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(state != FETCH || imem.ack),
    .enable(state == FETCH && !imem.ack),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = halt_req ? HALTED : run ? FETCH : IDLE;
      FETCH: state_n = imem.ack ? DECODE : expired ? ERROR : FETCH;
      DECODE: state_n = ir[6:0] == OPC_RTYPE ? EXECUTE : ir[6:0] == OPC_SYSTEM ? HALTED : ERROR;
      EXECUTE: state_n = WRITEBACK;
      WRITEBACK: state_n = halt_req ? HALTED : run ? FETCH : IDLE;
      HALTED, ERROR: state_n = clear ? IDLE : state;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      fetch_err <= 1'b0;
      illegal_instr <= 1'b0;
    end else begin
      state <= state_n;
      if (state == FETCH && imem.ack) ir <= imem.rdata;
      if (state == WRITEBACK) pc <= pc + PC_WIDTH'(PC_STEP);
      if (state == FETCH && state_n == ERROR) fetch_err <= 1'b1;
      if (state == DECODE && state_n == ERROR) illegal_instr <= 1'b1;
      if ((state == HALTED || state == ERROR) && clear) begin
        fetch_err <= 1'b0;
        illegal_instr <= 1'b0;
      end
    end
`ifdef SEQ_RETIRE_CNT_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) retire_count <= '0;
    else if (state == WRITEBACK) retire_count <= retire_count + 32'd1;
`endif
  assign imem.req = state == FETCH;
  assign imem.addr = pc;
  assign alu_en = state == EXECUTE;
  assign regwrite = state == WRITEBACK && ctrl_regwrite;
  assign halted = state == HALTED;
endmodule
